chipset_bus_steering: RTL and testbench

- Parametrised read-data steering and ready-generation block for the chipset read path.
- Generalises the fixed three-way read mux (peripherals / RAM / external) to NUM_SOURCES prioritised internal sources, each with its own wait-state count.
- Read data is latched, and ready is held off until the selected source has responded, with a timeout fallback to open-bus.
- Sits between the internal slaves and the bus arbiter's data_bus_ext input; bus_ready feeds the READY logic.

---
 rtl/chipset_bus_steering.sv | 147 ++++++++++++++
 tb/tb_chipset_bus_steering.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/chipset_bus_steering.sv
// Read-path steering for the chipset: picks the highest-priority claiming source,
// inserts its wait states, latches its data and falls back to open-bus on timeout.
module chipset_bus_steering #(
    parameter int NUM_SOURCES    = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int WAIT_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SRC_W         = $clog2(NUM_SOURCES + 1)
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              memory_read_n,
    input  logic                              io_read_n,
    input  logic [NUM_SOURCES-1:0]            source_select,
    input  logic [NUM_SOURCES-1:0]            source_ready,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] source_data,
    input  logic [NUM_SOURCES*WAIT_WIDTH-1:0] source_wait_states,
    input  logic [DATA_WIDTH-1:0]             external_data,
    output logic [DATA_WIDTH-1:0]             internal_data_bus_ext,
    output logic                              data_bus_direction,
    output logic                              bus_ready,
    output logic [SRC_W-1:0]                  active_source,
    output logic                              contention,
    output logic                              timeout
);

    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [SRC_W-1:0] EXTERNAL = SRC_W'(NUM_SOURCES);

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t                  state;
    logic                    read_active;
    logic                    read_active_q;
    logic                    start;
    logic [WAIT_WIDTH-1:0]   wait_cnt;
    logic [TO_W-1:0]         timeout_cnt;
    logic [DATA_WIDTH-1:0]   data_reg;

    logic [SRC_W-1:0]        pick_idx;
    logic [WAIT_WIDTH-1:0]   pick_wait;
    logic [SRC_W-1:0]        claim_cnt;
    logic                    win_ready;
    logic [DATA_WIDTH-1:0]   win_data;

    // Either strobe counts as one read; only a 0->1 edge of the combined strobe starts one.
    assign read_active = ~memory_read_n | ~io_read_n;
    assign start       = read_active & ~read_active_q;

    // Descending scan so the lowest claiming index is the one left standing.
    always_comb begin
        pick_idx  = EXTERNAL;
        pick_wait = '0;
        claim_cnt = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            claim_cnt = claim_cnt + SRC_W'(source_select[i]);
            if (source_select[i]) begin
                pick_idx  = SRC_W'(i);
                pick_wait = source_wait_states[i*WAIT_WIDTH +: WAIT_WIDTH];
            end
        end
    end

    always_comb begin
        win_ready = 1'b0;
        win_data  = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (active_source == SRC_W'(i)) begin
                win_ready = source_ready[i];
                win_data  = source_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // External reads pass the live external bus straight through while held.
    assign internal_data_bus_ext = data_bus_direction ? external_data : data_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            read_active_q      <= 1'b0;
            wait_cnt           <= '0;
            timeout_cnt        <= '0;
            data_reg           <= '0;
            data_bus_direction <= 1'b0;
            bus_ready          <= 1'b1;
            active_source      <= EXTERNAL;
            contention         <= 1'b0;
            timeout            <= 1'b0;
        end else begin
            read_active_q <= read_active;
            contention    <= 1'b0;
            timeout       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        active_source <= pick_idx;
                        contention    <= (claim_cnt > SRC_W'(1));
                        if (pick_idx == EXTERNAL) begin
                            state              <= HOLD;
                            data_bus_direction <= 1'b1;
                            bus_ready          <= 1'b1;
                        end else begin
                            state       <= COUNT;
                            wait_cnt    <= pick_wait;
                            timeout_cnt <= '0;
                            bus_ready   <= 1'b0;
                        end
                    end
                end
                COUNT: begin
                    if (!read_active) begin
                        state     <= IDLE;
                        bus_ready <= 1'b1;
                    end else if (wait_cnt == '0 && win_ready) begin
                        state     <= HOLD;
                        data_reg  <= win_data;
                        bus_ready <= 1'b1;
                    end else if (timeout_cnt == TO_LAST) begin
                        state     <= HOLD;
                        data_reg  <= '1;
                        timeout   <= 1'b1;
                        bus_ready <= 1'b1;
                    end else begin
                        if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                        if (timeout_cnt != TO_MAX) timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!read_active) begin
                        state              <= IDLE;
                        data_reg           <= '0;
                        data_bus_direction <= 1'b0;
                        bus_ready          <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chipset_bus_steering.sv
// Directed bench for chipset_bus_steering: single source, priority, external,
// timeout, abort and asynchronous reset, with hand-computed expectations.
module tb_chipset_bus_steering;

    logic        clock;
    logic        reset_n;
    logic        memory_read_n;
    logic        io_read_n;
    logic [3:0]  source_select;
    logic [3:0]  source_ready;
    logic [31:0] source_data;
    logic [11:0] source_wait_states;
    logic [7:0]  external_data;
    logic [7:0]  internal_data_bus_ext;
    logic        data_bus_direction;
    logic        bus_ready;
    logic [2:0]  active_source;
    logic        contention;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    chipset_bus_steering #(
        .NUM_SOURCES(4),
        .DATA_WIDTH(8),
        .WAIT_WIDTH(3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .memory_read_n(memory_read_n),
        .io_read_n(io_read_n),
        .source_select(source_select),
        .source_ready(source_ready),
        .source_data(source_data),
        .source_wait_states(source_wait_states),
        .external_data(external_data),
        .internal_data_bus_ext(internal_data_bus_ext),
        .data_bus_direction(data_bus_direction),
        .bus_ready(bus_ready),
        .active_source(active_source),
        .contention(contention),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n            = 1'b0;
        memory_read_n      = 1'b1;
        io_read_n          = 1'b1;
        source_select      = 4'b0000;
        source_ready       = 4'b1111;
        source_data        = 32'h0;
        source_wait_states = 12'h0;
        external_data      = 8'h00;

        // Reset then idle
        repeat (3) tick();
        check("rst_ready", 32'(bus_ready), 32'd1);
        check("rst_data", 32'(internal_data_bus_ext), 32'h00);
        check("rst_dir", 32'(data_bus_direction), 32'd0);
        check("rst_src", 32'(active_source), 32'd4);
        reset_n = 1'b1;
        tick();

        // Single source 1, wait 2
        source_select      = 4'b0010;
        source_wait_states = {3'd0, 3'd0, 3'd2, 3'd0};
        source_data        = {8'h00, 8'h00, 8'h5A, 8'h00};
        memory_read_n      = 1'b0;
        #1;
        check("single_pre_ready", 32'(bus_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single_wait_ready", 32'(bus_ready), 32'd0);
        end
        tick();
        check("single_ready", 32'(bus_ready), 32'd1);
        check("single_data", 32'(internal_data_bus_ext), 32'h5A);
        check("single_src", 32'(active_source), 32'd1);
        check("single_dir", 32'(data_bus_direction), 32'd0);
        check("single_contention", 32'(contention), 32'd0);
        memory_read_n = 1'b1;
        tick();
        check("single_idle_data", 32'(internal_data_bus_ext), 32'h00);
        check("single_idle_ready", 32'(bus_ready), 32'd1);

        // Priority and contention: sources 1 and 3 claim, 1 wins
        source_select      = 4'b1010;
        source_wait_states = 12'h0;
        source_data        = {8'h33, 8'h00, 8'h11, 8'h00};
        io_read_n          = 1'b0;
        tick();
        check("prio_contention", 32'(contention), 32'd1);
        check("prio_src", 32'(active_source), 32'd1);
        check("prio_ready_low", 32'(bus_ready), 32'd0);
        tick();
        check("prio_contention_clear", 32'(contention), 32'd0);
        check("prio_data", 32'(internal_data_bus_ext), 32'h11);
        check("prio_ready", 32'(bus_ready), 32'd1);
        // Strobe hand-over keeps read_active high: no restart, no new pulse
        source_data   = {8'h33, 8'h00, 8'h77, 8'h00};
        memory_read_n = 1'b0;
        tick();
        io_read_n = 1'b1;
        tick();
        check("toggle_data", 32'(internal_data_bus_ext), 32'h11);
        check("toggle_contention", 32'(contention), 32'd0);
        check("toggle_ready", 32'(bus_ready), 32'd1);
        memory_read_n = 1'b1;
        tick();
        check("prio_idle_data", 32'(internal_data_bus_ext), 32'h00);

        // External path
        source_select = 4'b0000;
        external_data = 8'hC3;
        memory_read_n = 1'b0;
        tick();
        check("ext_ready", 32'(bus_ready), 32'd1);
        check("ext_dir", 32'(data_bus_direction), 32'd1);
        check("ext_src", 32'(active_source), 32'd4);
        check("ext_data", 32'(internal_data_bus_ext), 32'hC3);
        external_data = 8'h3C;
        #1;
        check("ext_data_follow", 32'(internal_data_bus_ext), 32'h3C);
        memory_read_n = 1'b1;
        tick();
        check("ext_idle_dir", 32'(data_bus_direction), 32'd0);
        check("ext_idle_data", 32'(internal_data_bus_ext), 32'h00);

        // Timeout: source 0 never ready, open-bus after 8 wait cycles
        source_select = 4'b0001;
        source_ready  = 4'b0000;
        source_data   = 32'h0000_0055;
        memory_read_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_wait_ready", 32'(bus_ready), 32'd0);
            check("to_wait_pulse", 32'(timeout), 32'd0);
        end
        tick();
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_ready", 32'(bus_ready), 32'd1);
        check("to_data", 32'(internal_data_bus_ext), 32'hFF);
        tick();
        check("to_pulse_clear", 32'(timeout), 32'd0);
        memory_read_n = 1'b1;
        tick();
        check("to_idle_data", 32'(internal_data_bus_ext), 32'h00);

        // Abort from COUNT
        source_ready       = 4'b1111;
        source_wait_states = {3'd0, 3'd0, 3'd0, 3'd3};
        io_read_n          = 1'b0;
        tick();
        check("abort_ready_low0", 32'(bus_ready), 32'd0);
        tick();
        check("abort_ready_low1", 32'(bus_ready), 32'd0);
        io_read_n = 1'b1;
        tick();
        check("abort_ready", 32'(bus_ready), 32'd1);
        check("abort_data", 32'(internal_data_bus_ext), 32'h00);
        check("abort_timeout", 32'(timeout), 32'd0);
        check("abort_contention", 32'(contention), 32'd0);
        tick();
        check("abort_stay_ready", 32'(bus_ready), 32'd1);

        // Reset asserted mid-COUNT
        source_select = 4'b0011;
        memory_read_n = 1'b0;
        tick();
        check("rstmid_contention", 32'(contention), 32'd1);
        check("rstmid_ready_low", 32'(bus_ready), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstmid_ready", 32'(bus_ready), 32'd1);
        check("rstmid_src", 32'(active_source), 32'd4);
        check("rstmid_contention_clr", 32'(contention), 32'd0);
        check("rstmid_data", 32'(internal_data_bus_ext), 32'h00);
        memory_read_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        check("rstmid_after_ready", 32'(bus_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
